// File: rtl/snes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snes_pkg
//  Purpose  : Shared definitions for the SNES/NES pad protocol blocks
//             (snes_controller and snes_controller_responder): responder
//             state encoding, button bit positions and frame lengths.
//  Revision : 1.0  initial release
// ============================================================================
package snes_pkg;

    // Responder frame states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Button positions within the parallel word (bits 12-15 carry the pad ID)
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // Frame lengths
    localparam int SNES_BITS = 16;
    localparam int NES_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sync_edge
//  Purpose  : Two-flop synchronizer for an asynchronous input followed by a
//             registered previous-value stage used for rise/fall detection.
//             Pin change to asserted rise_o/fall_o is two clk_i edges, so a
//             register acting on them updates on the third edge.
//  Ports    : clk_i   - system clock
//             rst_i   - asynchronous active-high reset (all stages clear to 0)
//             async_i - asynchronous input pin
//             level_o - synchronized level
//             rise_o  - one-cycle strobe on a synchronized rising edge
//             fall_o  - one-cycle strobe on a synchronized falling edge
//  Revision : 1.0  initial release
// ============================================================================
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  =  sync_q & ~prev_q;
    assign fall_o  = ~sync_q &  prev_q;

endmodule
`default_nettype wire

// File: rtl/snes_controller_responder.sv
`default_nettype none
// ============================================================================
//  Module   : snes_controller_responder
//  Purpose  : Pad-side end of the SNES/NES serial protocol. Captures BUTTONS
//             (1 = pressed) while LATCH is high and shifts them out on DATA
//             active-low, LSB first, one bit per PULSE rising edge.
//  Ports    : CLOCK      - system clock (rising edge)
//             RESET      - asynchronous active-high reset
//             LATCH      - asynchronous latch from host
//             PULSE      - asynchronous shift clock from host
//             BUTTONS    - parallel button word, NUM_BITS wide
//             DATA       - registered serial data, 0 = pressed
//             BUSY       - high while in LOAD or SHIFT
//             FRAME_DONE - one-cycle strobe when the last bit has shifted
//  Options  : `define SNES_RESPONDER_WATCHDOG_EN to abandon a frame after
//             TIMEOUT_CYCLES clocks in SHIFT without any PULSE edge.
//  Revision : 1.0  initial release
// ============================================================================
module snes_controller_responder
    import snes_pkg::*;
#(
    parameter int NUM_BITS       = 16,
    parameter bit FILL_BIT       = 1'b0,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                LATCH,
    input  logic                PULSE,
    input  logic [NUM_BITS-1:0] BUTTONS,
    output logic                DATA,
    output logic                BUSY,
    output logic                FRAME_DONE
);

    localparam int                  c_CNT_W    = $clog2(NUM_BITS + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(NUM_BITS - 1);

    logic w_latch_level, w_latch_rise, w_latch_fall;
    logic w_pulse_level, w_pulse_rise, w_pulse_fall;

    sync_edge u_sync_latch (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .async_i (LATCH),
        .level_o (w_latch_level),
        .rise_o  (w_latch_rise),
        .fall_o  (w_latch_fall)
    );

    sync_edge u_sync_pulse (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .async_i (PULSE),
        .level_o (w_pulse_level),
        .rise_o  (w_pulse_rise),
        .fall_o  (w_pulse_fall)
    );

    state_t                 state_q;
    logic [NUM_BITS-1:0]    sr_q;
    logic [c_CNT_W-1:0]     cnt_q;
    logic                   busy_q;
    logic                   done_q;

`ifdef SNES_RESPONDER_WATCHDOG_EN
    localparam int                 c_WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0]  c_WD_LIMIT = c_WD_W'(TIMEOUT_CYCLES);
    logic [c_WD_W-1:0]      wd_q;
`endif

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            sr_q    <= '1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SNES_RESPONDER_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            // A new latch always restarts the frame; it also beats a
            // coincident PULSE edge, so no shift happens in that cycle.
            if (w_latch_rise) begin
                state_q <= ST_LOAD;
                sr_q    <= ~BUTTONS;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_latch_level) begin
                            state_q <= ST_LOAD;
                            sr_q    <= ~BUTTONS;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        // Transparent load, like the 4021 in a real pad
                        sr_q  <= ~BUTTONS;
                        cnt_q <= '0;
                        if (w_latch_fall) begin
                            state_q <= ST_SHIFT;
`ifdef SNES_RESPONDER_WATCHDOG_EN
                            wd_q    <= '0;
`endif
                        end
                    end
                    ST_SHIFT: begin
                        if (w_pulse_rise) begin
                            sr_q  <= {FILL_BIT, sr_q[NUM_BITS-1:1]};
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == c_CNT_LAST) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
`ifdef SNES_RESPONDER_WATCHDOG_EN
                        if (w_pulse_rise || w_pulse_fall) begin
                            wd_q <= '0;
                        end else if (wd_q == c_WD_LIMIT) begin
                            state_q <= ST_IDLE;
                            sr_q    <= '1;
                            busy_q  <= 1'b0;
                        end else begin
                            wd_q <= wd_q + 1'b1;
                        end
`endif
                    end
                    ST_DONE: begin
                        // bit count stays saturated; only fill bits move
                        if (w_pulse_rise) begin
                            sr_q <= {FILL_BIT, sr_q[NUM_BITS-1:1]};
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DATA       = sr_q[0];
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_snes_controller_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snes_controller_responder
//  Purpose  : Directed self-checking bench for snes_controller_responder.
//             Host-side timing: LATCH high 12 clocks, PULSE 6 high / 6 low.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_snes_controller_responder;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        LATCH = 1'b0;
    logic        PULSE = 1'b0;
    logic [15:0] BUTTONS = 16'h0000;
    logic        DATA;
    logic        BUSY;
    logic        FRAME_DONE;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fd_cnt  = 0;
    int fd_cyc  = -1;

    snes_controller_responder #(
        .NUM_BITS       (16),
        .FILL_BIT       (1'b0),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .LATCH      (LATCH),
        .PULSE      (PULSE),
        .BUTTONS    (BUTTONS),
        .DATA       (DATA),
        .BUSY       (BUSY),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(negedge CLOCK) begin
        if (FRAME_DONE === 1'b1) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic pulse();
        PULSE = 1'b1;
        tick(6);
        PULSE = 1'b0;
        tick(6);
    endtask

    // Latch b, check DATA shows ~b[0] during the latch, then release and
    // wait long enough for the falling edge to reach the state machine.
    task automatic latch_frame(input logic [15:0] b);
        BUTTONS = b;
        LATCH   = 1'b1;
        tick(12);
        check_eq("latch_data", {31'd0, DATA}, {31'd0, ~b[0]});
        LATCH = 1'b0;
        tick(6);
    endtask

    // Full 16-bit frame: returns the captured serial word and the cycle
    // number at which the 16th PULSE was raised.
    task automatic full_frame(input logic [15:0] b, output logic [15:0] w, output int c16);
        latch_frame(b);
        w[0] = DATA;
        for (int i = 1; i < 16; i++) begin
            pulse();
            w[i] = DATA;
        end
        c16 = cyc;
        pulse();
    endtask

    initial begin
        logic [15:0] word;
        int          c16;
        int          fd0;

        // Reset state
        tick(3);
        check_eq("rst_data", {31'd0, DATA}, 32'd1);
        check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
        check_eq("rst_fd",   {31'd0, FRAME_DONE}, 32'd0);
        RESET = 1'b0;
        tick(2);

        // 1: asynchronous reset mid-frame
        latch_frame(16'hFFFF);
        for (int i = 0; i < 7; i++) pulse();
        check_eq("t1_busy_pre", {31'd0, BUSY}, 32'd1);
        check_eq("t1_data_pre", {31'd0, DATA}, 32'd0);
        #2;
        RESET = 1'b1;
        #1;
        check_eq("t1_data", {31'd0, DATA}, 32'd1);
        check_eq("t1_busy", {31'd0, BUSY}, 32'd0);
        check_eq("t1_fd",   {31'd0, FRAME_DONE}, 32'd0);
        tick(2);
        RESET = 1'b0;
        tick(2);

        // 2: single B press, FRAME_DONE timing
        fd0 = fd_cnt;
        full_frame(16'h0001, word, c16);
        check_eq("t2_word",   {16'd0, word}, 32'h0000FFFE);
        check_eq("t2_fill",   {31'd0, DATA}, 32'd0);
        check_eq("t2_busy",   {31'd0, BUSY}, 32'd0);
        check_eq("t2_fd_cnt", fd_cnt - fd0, 32'd1);
        check_eq("t2_fd_lat", fd_cyc - c16, 32'd3);

        // 3: mixed pattern plus overrun pulses
        fd0 = fd_cnt;
        full_frame(16'hA5C3, word, c16);
        check_eq("t3_word",   {16'd0, word}, 32'h00005A3C);
        check_eq("t3_fd_lat", fd_cyc - c16, 32'd3);
        for (int i = 17; i <= 20; i++) begin
            pulse();
            check_eq("t3_extra", {31'd0, DATA}, 32'd0);
        end
        check_eq("t3_fd_cnt", fd_cnt - fd0, 32'd1);

        // 4: aborted frame then relatch
        fd0 = fd_cnt;
        latch_frame(16'h0000);
        for (int i = 0; i < 5; i++) pulse();
        check_eq("t4_no_fd", fd_cnt - fd0, 32'd0);
        full_frame(16'h0800, word, c16);
        check_eq("t4_word",   {16'd0, word}, 32'h0000F7FF);
        check_eq("t4_fd_cnt", fd_cnt - fd0, 32'd1);

        // 5: LATCH and PULSE rising together
        BUTTONS = 16'h0002;
        LATCH   = 1'b1;
        PULSE   = 1'b1;
        tick(12);
        LATCH = 1'b0;
        tick(6);
        check_eq("t5_bit0", {31'd0, DATA}, 32'd1);
        PULSE = 1'b0;
        tick(6);
        PULSE = 1'b1;
        tick(6);
        check_eq("t5_bit1", {31'd0, DATA}, 32'd0);
        PULSE = 1'b0;
        tick(6);

        // 6: stalled host
        latch_frame(16'hFFFF);
        for (int i = 0; i < 3; i++) pulse();
        tick(120);
`ifdef SNES_RESPONDER_WATCHDOG_EN
        check_eq("t6_busy", {31'd0, BUSY}, 32'd0);
        check_eq("t6_data", {31'd0, DATA}, 32'd1);
`else
        check_eq("t6_busy", {31'd0, BUSY}, 32'd1);
        check_eq("t6_data", {31'd0, DATA}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
